ofmap_writer: RTL and testbench
===============================

Name: ofmap_writer

Overview:
- Drains one captured column of PE-array results (X_DIM signed 2*DATA_WIDTH-bit partial sums) into the output-feature-map buffer.
- Writes one element per accepted write beat.
- Sits between the PE array's registered pe_out vector and the ofmap SRAM write port; it is the consuming end of the array's output interface.
- Applies optional ReLU, arithmetic right-shift requantization and saturation to DATA_WIDTH before each write.

Parameters:
- X_DIM, 15, number of PE rows; elements per capture.
- DATA_WIDTH, 8, output element width; input elements are 2*DATA_WIDTH.
- ADDR_WIDTH, 10, ofmap buffer address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cap_valid  input  1  pe_out vector is valid this cycle.
- cap_ready  output  1  block can capture a vector.
- pe_out  input  [2*DATA_WIDTH-1:0] x [X_DIM-1:0]  signed partial sums from the PE array.
- base_addr  input  ADDR_WIDTH  buffer address for element 0, sampled at capture.
- shift  input  4  right-shift amount, sampled at capture.
- relu_en  input  1  clamp negatives to 0, sampled at capture.
- buf_wr_en  output  1  write request.
- buf_wr_ready  input  1  buffer accepts the write this cycle.
- buf_wr_addr  output  ADDR_WIDTH  write address.
- buf_wr_data  output  DATA_WIDTH  signed requantized element.
- busy  output  1  high in DRAIN and DONE.
- done  output  1  one-cycle pulse after the last write is accepted.

Behaviour:
- Reset values while rst=0:
  - state=IDLE.
  - cap_ready=1.
  - buf_wr_en=0, buf_wr_addr=0, buf_wr_data=0.
  - busy=0, done=0, idx=0.
  - Capture registers cleared.
- State machine IDLE -> DRAIN -> DONE -> IDLE:
  - IDLE: cap_ready=1. On cap_valid&&cap_ready, register all X_DIM elements, base_addr, shift and relu_en; set idx=0; go to DRAIN.
  - DRAIN: cap_ready=0 and cap_valid is ignored. buf_wr_en=1, buf_wr_addr=(base+idx) mod 2^ADDR_WIDTH, buf_wr_data=requant(cap[idx]).
    - Beat completes when buf_wr_en&&buf_wr_ready. idx then increments.
    - When the beat with idx==X_DIM-1 completes, go to DONE.
  - DONE: buf_wr_en=0, done=1 for exactly one cycle, then IDLE.
- Handshake:
  - buf_wr_addr and buf_wr_data are driven from registers and stay stable while buf_wr_en=1 and buf_wr_ready=0.
  - buf_wr_en never drops mid-drain.
- Latency:
  - Capture on edge N.
  - First write presented in cycle N+1.
  - With buf_wr_ready held high: X_DIM consecutive beats, done in cycle N+1+X_DIM, cap_ready high again in cycle N+2+X_DIM.
- Requant arithmetic, per element:
  - v = signed 2*DATA_WIDTH.
  - If relu_en and v<0, then v=0.
  - v = v >>> shift (arithmetic; shift up to 15 yields sign fill).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Address wrap-around: base_addr+idx overflows modulo 2^ADDR_WIDTH with no error flag.
- Reset mid-drain: return to IDLE immediately. Remaining writes are abandoned, buf_wr_en drops asynchronously, and no done is issued.
- Capture inputs changing during DRAIN have no effect.

Optional Feature:
- Macro: OFMAP_WR_ROUND_EN.
- Defined: round-half-up before the shift. When shift>0, add 1<<(shift-1) in a 2*DATA_WIDTH+1-bit intermediate, then shift and saturate. This is applied after ReLU.
- Undefined: plain truncating arithmetic shift, i.e. floor toward -inf.
- Latency and handshake are identical in both builds.

Decomposition:
- Package ofmap_pkg holds:
  - state enum (IDLE, DRAIN, DONE);
  - function-free constants for the saturation bounds derived from DATA_WIDTH;
  - SHIFT_WIDTH=4.
- One sub-module, ofmap_requant: purely combinational ReLU/round/shift/saturate for a single element. Instantiate it once and mux cap[idx] into it.
- ofmap_writer holds the FSM, idx counter, capture registers and output registers.

Test Plan:
- Back-to-back drain: X_DIM=15, pe_out[i]=i, base=0x010, shift=0, relu=0, buf_wr_ready=1 -> 15 writes at 0x010..0x01E with data 0..14 in consecutive cycles; done exactly 16 cycles after the capture edge.
- Saturation and ReLU:
  - pe_out[0]=300, shift=1 -> 127.
  - pe_out[1]=-20, relu=1 -> 0.
  - pe_out[1]=-20, relu=0, shift=2 -> -5.
  - pe_out[2]=-1000, shift=0 -> -128.
- Backpressure: buf_wr_ready low for 3 cycles at idx 4 -> addr and data held constant for those cycles; idx 5 appears only after the accepting cycle; total writes still 15; done delayed by 3 cycles.
- Wrap and ignore: base=0x3FA, ADDR_WIDTH=10 -> addresses 0x3FA..0x3FF then 0x000..0x008. cap_valid pulsed during DRAIN with new data -> ignored; cap_ready stays 0.
- Reset mid-drain: assert rst at idx 7 -> buf_wr_en=0 immediately, no done. After release, cap_ready=1 and a new capture drains from idx 0.
- Rounding, per build, for 7 and -7 with shift=1:
  - OFMAP_WR_ROUND_EN defined -> 4 and -3.
  - OFMAP_WR_ROUND_EN undefined -> 3 and -4.

Source files
------------

// File: rtl/ofmap_pkg.sv
// Shared types and constants for the ofmap writer: FSM states, shift width, saturation bounds.
package ofmap_pkg;

   localparam int unsigned SHIFT_WIDTH    = 4;
   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int          SAT_MAX        = (1 << (DEF_DATA_WIDTH - 1)) - 1;
   localparam int          SAT_MIN        = -(1 << (DEF_DATA_WIDTH - 1));

   typedef enum logic [1:0] {
      StIdle,
      StDrain,
      StDone
   } ofmap_state_e;

endpackage

// File: rtl/ofmap_requant.sv
// Combinational ReLU / optional round-half-up / arithmetic shift / saturate for one element.
// Rounding is compiled in when OFMAP_WR_ROUND_EN is defined.
module ofmap_requant
   import ofmap_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [2*DATA_WIDTH-1:0] din,
   input  logic [SHIFT_WIDTH-1:0]  shift,
   input  logic                    relu_en,
   output logic [DATA_WIDTH-1:0]   dout
);

   localparam int unsigned WideW = 2 * DATA_WIDTH + 1;
   localparam logic signed [WideW-1:0] SatHi = WideW'((1 << (DATA_WIDTH - 1)) - 1);
   localparam logic signed [WideW-1:0] SatLo = WideW'(-(1 << (DATA_WIDTH - 1)));

   logic signed [WideW-1:0] v;
   logic signed [WideW-1:0] shifted;

   always_comb begin
      // One extra bit of headroom so the rounding add cannot overflow.
      v = {din[2*DATA_WIDTH-1], din};
      if (relu_en && din[2*DATA_WIDTH-1]) begin
         v = '0;
      end
`ifdef OFMAP_WR_ROUND_EN
      if (shift != '0) begin
         v = v + (WideW'(1) << (shift - 1'b1));
      end
`endif
      shifted = v >>> shift;
      if (shifted > SatHi) begin
         dout = SatHi[DATA_WIDTH-1:0];
      end else if (shifted < SatLo) begin
         dout = SatLo[DATA_WIDTH-1:0];
      end else begin
         dout = shifted[DATA_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/ofmap_writer.sv
// Captures one PE-array column and drains it element by element into the ofmap buffer.
// Define OFMAP_WR_ROUND_EN to enable round-half-up requantization (see ofmap_requant).
module ofmap_writer
   import ofmap_pkg::*;
#(
   parameter int unsigned X_DIM      = 15,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 cap_valid,
   output logic                                 cap_ready,
   input  logic [X_DIM-1:0][2*DATA_WIDTH-1:0]   pe_out,
   input  logic [ADDR_WIDTH-1:0]                base_addr,
   input  logic [SHIFT_WIDTH-1:0]               shift,
   input  logic                                 relu_en,
   output logic                                 buf_wr_en,
   input  logic                                 buf_wr_ready,
   output logic [ADDR_WIDTH-1:0]                buf_wr_addr,
   output logic [DATA_WIDTH-1:0]                buf_wr_data,
   output logic                                 busy,
   output logic                                 done
);

   localparam int unsigned IdxW = (X_DIM > 1) ? $clog2(X_DIM) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(X_DIM - 1);

   ofmap_state_e                       state_q;
   logic [X_DIM-1:0][2*DATA_WIDTH-1:0] cap_q;
   logic [ADDR_WIDTH-1:0]              base_q;
   logic [SHIFT_WIDTH-1:0]             shift_q;
   logic                               relu_q;
   logic [IdxW-1:0]                    idx_q;
   logic [IdxW-1:0]                    idx_nxt;

   logic [2*DATA_WIDTH-1:0]            rq_din;
   logic [SHIFT_WIDTH-1:0]             rq_shift;
   logic                               rq_relu;
   logic [DATA_WIDTH-1:0]              rq_dout;

   // The requantizer always prepares the element that will be presented next, so the
   // output registers can be loaded on the capture edge and on each accepted beat.
   always_comb begin
      idx_nxt = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
      if (state_q == StIdle) begin
         rq_din   = pe_out[0];
         rq_shift = shift;
         rq_relu  = relu_en;
      end else begin
         rq_din   = cap_q[idx_nxt];
         rq_shift = shift_q;
         rq_relu  = relu_q;
      end
   end

   ofmap_requant #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_requant (
      .din     (rq_din),
      .shift   (rq_shift),
      .relu_en (rq_relu),
      .dout    (rq_dout)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cap_q       <= '0;
         base_q      <= '0;
         shift_q     <= '0;
         relu_q      <= 1'b0;
         idx_q       <= '0;
         cap_ready   <= 1'b1;
         buf_wr_en   <= 1'b0;
         buf_wr_addr <= '0;
         buf_wr_data <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cap_valid && cap_ready) begin
                  cap_q       <= pe_out;
                  base_q      <= base_addr;
                  shift_q     <= shift;
                  relu_q      <= relu_en;
                  idx_q       <= '0;
                  cap_ready   <= 1'b0;
                  buf_wr_en   <= 1'b1;
                  buf_wr_addr <= base_addr;
                  buf_wr_data <= rq_dout;
                  busy        <= 1'b1;
                  state_q     <= StDrain;
               end
            end
            StDrain: begin
               if (buf_wr_ready) begin
                  if (idx_q == LastIdx) begin
                     buf_wr_en <= 1'b0;
                     done      <= 1'b1;
                     state_q   <= StDone;
                  end else begin
                     idx_q       <= idx_nxt;
                     buf_wr_addr <= base_q + ADDR_WIDTH'(idx_nxt);
                     buf_wr_data <= rq_dout;
                  end
               end
            end
            StDone: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               cap_ready <= 1'b1;
               state_q   <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ofmap_writer.sv
// Randomized self-checking bench for ofmap_writer against an arithmetic requant model.
module tb_ofmap_writer;
   import ofmap_pkg::*;

   localparam int X  = 15;
   localparam int DW = 8;
   localparam int AW = 10;

   typedef logic [X-1:0][2*DW-1:0] vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          cap_valid;
   logic          cap_ready;
   vec_t          pe_out;
   logic [AW-1:0] base_addr;
   logic [3:0]    shift;
   logic          relu_en;
   logic          buf_wr_en;
   logic          buf_wr_ready;
   logic [AW-1:0] buf_wr_addr;
   logic [DW-1:0] buf_wr_data;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_errors = 0;
   int obs_data [X];

   always #5 clk = ~clk;

   ofmap_writer #(
      .X_DIM      (X),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cap_valid    (cap_valid),
      .cap_ready    (cap_ready),
      .pe_out       (pe_out),
      .base_addr    (base_addr),
      .shift        (shift),
      .relu_en      (relu_en),
      .buf_wr_en    (buf_wr_en),
      .buf_wr_ready (buf_wr_ready),
      .buf_wr_addr  (buf_wr_addr),
      .buf_wr_data  (buf_wr_data),
      .busy         (busy),
      .done         (done)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_requant(input int v, input int sh, input bit relu);
      int r;
      r = v;
      if (relu && r < 0) r = 0;
`ifdef OFMAP_WR_ROUND_EN
      if (sh > 0) r = r + (1 << (sh - 1));
`endif
      r = r >>> sh;
      if (r > SAT_MAX) r = SAT_MAX;
      if (r < SAT_MIN) r = SAT_MIN;
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < X; i++) begin
         if ($urandom % 2 == 0) v[i] = 16'($urandom_range(600) - 300);
         else v[i] = 16'($urandom);
      end
      return v;
   endfunction

   // mode 0: ready always high, 1: random ready, 2: three stall cycles at element 4.
   // abort_at >= 0 asserts reset while that element is being presented.
   task automatic drain(input vec_t vals, input int base, input int sh, input bit relu,
                        input int mode, input int abort_at);
      int k      = 0;
      int cyc    = 0;
      int stalls = 0;
      bit rdy;
      pe_out    = vals;
      base_addr = AW'(base);
      shift     = 4'(sh);
      relu_en   = relu;
      cap_valid = 1'b1;
      @(negedge clk);
      cap_valid = 1'b0;
      cyc = 1;
      while (k < X) begin
         if (cyc > 200) begin
            check("drain_timeout", k, X);
            cap_valid = 1'b0;
            return;
         end
         check("wr_en_drain", int'(buf_wr_en), 1);
         check("cap_ready_drain", int'(cap_ready), 0);
         check("busy_drain", int'(busy), 1);
         check("done_drain", int'(done), 0);
         check($sformatf("addr[%0d]", k), int'(buf_wr_addr), (base + k) % (1 << AW));
         check($sformatf("data[%0d]", k), int'($signed(buf_wr_data)),
               ref_requant(int'($signed(vals[k])), sh, relu));
         obs_data[k] = int'($signed(buf_wr_data));
         if (k == abort_at) begin
            cap_valid = 1'b0;
            rst = 1'b0;
            #1;
            check("rst_wr_en", int'(buf_wr_en), 0);
            check("rst_done", int'(done), 0);
            check("rst_cap_ready", int'(cap_ready), 1);
            check("rst_busy", int'(busy), 0);
            return;
         end
         case (mode)
            1:       rdy = ($urandom % 3) != 0;
            2:       rdy = !(k == 4 && stalls < 3);
            default: rdy = 1'b1;
         endcase
         if (!rdy) stalls++;
         buf_wr_ready = rdy;
         // Capture-side noise that must be ignored while draining.
         cap_valid = 1'($urandom);
         pe_out    = rand_vec();
         base_addr = AW'($urandom);
         shift     = 4'($urandom);
         relu_en   = 1'($urandom);
         @(negedge clk);
         cyc++;
         if (rdy) k++;
      end
      cap_valid    = 1'b0;
      buf_wr_ready = 1'($urandom);
      check("done_pulse", int'(done), 1);
      check("wr_en_done", int'(buf_wr_en), 0);
      check("done_latency", cyc, X + 1 + stalls);
      check("cap_ready_done", int'(cap_ready), 0);
      check("busy_done", int'(busy), 1);
      @(negedge clk);
      check("done_clear", int'(done), 0);
      check("cap_ready_idle", int'(cap_ready), 1);
      check("busy_idle", int'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vals;
      rst          = 1'b0;
      cap_valid    = 1'b0;
      pe_out       = '0;
      base_addr    = '0;
      shift        = '0;
      relu_en      = 1'b0;
      buf_wr_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_cap_ready", int'(cap_ready), 1);
      check("reset_wr_en", int'(buf_wr_en), 0);
      check("reset_addr", int'(buf_wr_addr), 0);
      check("reset_data", int'(buf_wr_data), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < X; i++) vals[i] = 16'(i);
      drain(vals, 'h010, 0, 1'b0, 0, -1);

      vals    = rand_vec();
      vals[0] = 16'(300);
      vals[1] = 16'(-20);
      vals[2] = 16'(-1000);
      drain(vals, 'h020, 1, 1'b0, 0, -1);
      check("sat_pos", obs_data[0], 127);
      check("sat_neg_shift", obs_data[2], -128);
      drain(vals, 'h030, 0, 1'b1, 0, -1);
      check("relu_neg", obs_data[1], 0);
      drain(vals, 'h040, 2, 1'b0, 0, -1);
      check("shift_neg", obs_data[1], -5);
      drain(vals, 'h050, 0, 1'b0, 1, -1);
      check("sat_neg", obs_data[2], -128);

      vals[0] = 16'(7);
      vals[1] = 16'(-7);
      drain(vals, 'h060, 1, 1'b0, 0, -1);
`ifdef OFMAP_WR_ROUND_EN
      check("round_pos", obs_data[0], 4);
      check("round_neg", obs_data[1], -3);
`else
      check("trunc_pos", obs_data[0], 3);
      check("trunc_neg", obs_data[1], -4);
`endif

      drain(rand_vec(), 'h100, int'($urandom % 16), 1'($urandom), 2, -1);
      drain(rand_vec(), 'h3FA, 0, 1'b0, 1, -1);

      drain(rand_vec(), 'h070, 3, 1'b0, 0, 7);
      repeat (2) begin
         @(negedge clk);
         check("rst_hold_done", int'(done), 0);
         check("rst_hold_wr_en", int'(buf_wr_en), 0);
      end
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_cap_ready", int'(cap_ready), 1);
      drain(rand_vec(), 'h070, 3, 1'b0, 0, -1);

      repeat (8) begin
         drain(rand_vec(), int'($urandom % 1024), int'($urandom % 16), 1'($urandom), 1, -1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
